evt_state_clear_sequencer: RTL

Controller that initializes the neuron state memory of selected datapath groups before a new inference layer, and shares each group's state write port between the engine datapath and the sweep. On a start pulse it walks every neuron address from 0 to a configured last address and writes a fixed init value into each masked group. Unmasked groups keep full datapath access throughout. It sits between the datapath state-write requesters and the state memory write ports, in the engine clock domain.

---
 rtl/evt_state_clear_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/evt_state_clear_sequencer.sv
// rtl/evt_state_clear_sequencer.sv - neuron state memory clear sweep with datapath write-port sharing
//
// Ports:
//   engine_clk_i, engine_rst_ni     : clock, synchronous active-low reset
//   start_i                         : single-cycle sweep request (honoured only in IDLE)
//   group_mask_i, last_addr_i,
//   init_value_i                    : sweep configuration, latched on an accepted start
//   busy_o, done_o                  : sweep in progress / one-cycle completion pulse
//   dp_req_i, dp_addr_i, dp_wdata_i : datapath write requests, one slice per group
//   dp_gnt_o                        : datapath write accepted
//   mem_req_o, mem_addr_o,
//   mem_wdata_o                     : state memory write ports, one slice per group
//   mem_gnt_i                       : state memory accepted the write this cycle
module evt_state_clear_sequencer #(
    parameter int DP_GROUP           = 16,
    parameter int NEURONS_ADDR_WIDTH = 10,
    parameter int STATE_DATA_WIDTH   = 32
) (
    input  logic                                   engine_clk_i,
    input  logic                                   engine_rst_ni,
    input  logic                                   start_i,
    input  logic [DP_GROUP-1:0]                    group_mask_i,
    input  logic [NEURONS_ADDR_WIDTH-1:0]          last_addr_i,
    input  logic [STATE_DATA_WIDTH-1:0]            init_value_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    input  logic [DP_GROUP-1:0]                    dp_req_i,
    input  logic [DP_GROUP*NEURONS_ADDR_WIDTH-1:0] dp_addr_i,
    input  logic [DP_GROUP*STATE_DATA_WIDTH-1:0]   dp_wdata_i,
    output logic [DP_GROUP-1:0]                    dp_gnt_o,
    output logic [DP_GROUP-1:0]                    mem_req_o,
    output logic [DP_GROUP*NEURONS_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DP_GROUP*STATE_DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DP_GROUP-1:0]                    mem_gnt_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]                    state_q, state_d;
    logic [NEURONS_ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DP_GROUP-1:0]           acc_q, acc_d;
    logic [DP_GROUP-1:0]           mask_q, mask_d;
    logic [NEURONS_ADDR_WIDTH-1:0] last_q, last_d;
    logic [STATE_DATA_WIDTH-1:0]   init_q, init_d;

    logic sweep;
    logic addr_done;

    assign sweep = (state_q == ST_SWEEP);

    // A masked group still waiting always has its request up, so its grant
    // alone finishes it; unmasked groups never hold the address back.
    assign addr_done = &(~mask_q | acc_q | mem_gnt_i);

    // Write-port mux: masked groups belong to the sweep only while in SWEEP.
    always_comb begin
        mem_req_o   = dp_req_i;
        mem_addr_o  = dp_addr_i;
        mem_wdata_o = dp_wdata_i;
        dp_gnt_o    = mem_gnt_i;
        for (int g = 0; g < DP_GROUP; g++) begin
            if (sweep && mask_q[g]) begin
                mem_req_o[g]                                           = ~acc_q[g];
                mem_addr_o[g*NEURONS_ADDR_WIDTH +: NEURONS_ADDR_WIDTH] = cnt_q;
                mem_wdata_o[g*STATE_DATA_WIDTH +: STATE_DATA_WIDTH]    = init_q;
                dp_gnt_o[g]                                            = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mask_d  = mask_q;
        last_d  = last_q;
        init_d  = init_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mask_d  = group_mask_i;
                    last_d  = last_addr_i;
                    init_d  = init_value_i;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = (group_mask_i == '0) ? ST_DONE : ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (addr_done) begin
                    acc_d = '0;
                    if (cnt_q < last_q) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    acc_d = acc_q | (mask_q & ~acc_q & mem_gnt_i);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge engine_clk_i) begin
        if (!engine_rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mask_q  <= '0;
            last_q  <= '0;
            init_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mask_q  <= mask_d;
            last_q  <= last_d;
            init_q  <= init_d;
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);

endmodule
